// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU self-test sequencer: FSM states,
// the fixed operand table and the default MISR polynomial/seed.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam int NUM_VEC = 9;
    localparam int VIDX_W  = $clog2(NUM_VEC);

    // Operand pairs in two's complement; negative entries written as raw hex.
    localparam logic [31:0] VEC_A [NUM_VEC] = '{
        32'd0,
        32'd1234567890,
        32'd2345678901,
        32'd30,
        32'd50,
        32'hFFFF_FFF6,
        32'd20,
        32'hFFFF_FFC4,
        32'hFFFF_FFC4
    };

    localparam logic [31:0] VEC_B [NUM_VEC] = '{
        32'd0,
        32'd876543021,
        32'd3456789012,
        32'd40,
        32'd40,
        32'd10,
        32'hFFFF_FFEC,
        32'hFFFF_FFCE,
        32'hFFFF_FFBA
    };

    localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] DEF_MISR_SEED = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_bist_misr.sv
// Multiple-input signature register: shift-left with polynomial feedback,
// XOR-ing in one data word per enabled cycle. Resets to zero, not to the seed.
module alu_bist_misr
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(DEF_MISR_POLY),
    parameter logic [WIDTH-1:0] MISR_SEED = WIDTH'(DEF_MISR_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_seed,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sig_out
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] feedback;

    always_comb begin
        feedback = sig_q[WIDTH-1] ? MISR_POLY : '0;
        sig_d    = sig_q;
        if (load_seed) begin
            sig_d = MISR_SEED;
        end else if (shift_en) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ feedback ^ data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_out = sig_q;

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: sweeps every ctrl code over the operand table and
// compacts each result into a MISR. Define ALU_BIST_GOLDEN_CHECK_EN to grade against GOLDEN_SIG.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               CTRL_W     = 4,
    parameter int               SETTLE     = 1,
    parameter logic [WIDTH-1:0] MISR_POLY  = WIDTH'(DEF_MISR_POLY),
    parameter logic [WIDTH-1:0] MISR_SEED  = WIDTH'(DEF_MISR_SEED),
    parameter logic [WIDTH-1:0] GOLDEN_SIG = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_o,
    output logic [WIDTH-1:0]  signature,
    output logic [7:0]        vec_cnt,
    output logic              pass
);

    localparam int                SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [VIDX_W-1:0] LAST_VIDX   = VIDX_W'(NUM_VEC - 1);

    state_e              state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d, ctrl_nxt;
    logic [VIDX_W-1:0]   vidx_q, vidx_d, vidx_nxt;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                pass_q, pass_d;
    logic                misr_load;
    logic                misr_shift;
    logic                last_sample;
    logic                golden_hit;
    logic [WIDTH-1:0]    sig;

    alu_bist_misr #(
        .WIDTH     (WIDTH),
        .MISR_POLY (MISR_POLY),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .load_seed (misr_load),
        .shift_en  (misr_shift),
        .data_in   (alu_o),
        .sig_out   (sig)
    );

`ifdef ALU_BIST_GOLDEN_CHECK_EN
    // Grade the value the MISR is about to take on the final sample edge.
    logic [WIDTH-1:0] sig_next;
    assign sig_next   = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? MISR_POLY : '0) ^ alu_o;
    assign golden_hit = (sig_next == GOLDEN_SIG);
`else
    assign golden_hit = 1'b0;
`endif

    assign last_sample = (ctrl_q == {CTRL_W{1'b1}}) && (vidx_q == LAST_VIDX);

    always_comb begin
        if (vidx_q == LAST_VIDX) begin
            vidx_nxt = '0;
            ctrl_nxt = ctrl_q + CTRL_W'(1);
        end else begin
            vidx_nxt = vidx_q + VIDX_W'(1);
            ctrl_nxt = ctrl_q;
        end
    end

    // start is a level sampled only in IDLE; done is a one-cycle pulse in FINISH and
    // busy covers WAIT/SAMPLE, so a start seen while busy or in FINISH is dropped.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        ctrl_d     = ctrl_q;
        vidx_d     = vidx_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        misr_load  = 1'b0;
        misr_shift = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ctrl_d    = '0;
                    vidx_d    = '0;
                    a_d       = WIDTH'(VEC_A[0]);
                    b_d       = WIDTH'(VEC_B[0]);
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    settle_d  = '0;
                    misr_load = 1'b1;
                    state_d   = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end
            WAIT: begin
                if (settle_q == LAST_SETTLE) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            SAMPLE: begin
                misr_shift = 1'b1;
                cnt_d      = cnt_q + 8'd1;
                if (last_sample) begin
                    pass_d  = golden_hit;
                    state_d = FINISH;
                end else begin
                    vidx_d  = vidx_nxt;
                    ctrl_d  = ctrl_nxt;
                    a_d     = WIDTH'(VEC_A[vidx_nxt]);
                    b_d     = WIDTH'(VEC_B[vidx_nxt]);
                    state_d = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            ctrl_q   <= '0;
            vidx_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ctrl_q   <= ctrl_d;
            vidx_q   <= vidx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
        end
    end

    assign busy      = (state_q == WAIT) || (state_q == SAMPLE);
    assign done      = (state_q == FINISH);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctrl  = ctrl_q;
    assign signature = sig;
    assign vec_cnt   = cnt_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: one instance with SETTLE=1 and one with SETTLE=0,
// a behavioural ALU, a signature model, a sample-sequence scoreboard and corner-case sequences.
module tb_alu_bist;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    localparam int NV = 9;
    localparam int NS = 144;

    localparam logic [31:0] TA [NV] = '{32'd0, 32'd1234567890, 32'd2345678901, 32'd30, 32'd50,
                                        32'hFFFF_FFF6, 32'd20, 32'hFFFF_FFC4, 32'hFFFF_FFC4};
    localparam logic [31:0] TB [NV] = '{32'd0, 32'd876543021, 32'd3456789012, 32'd40, 32'd40,
                                        32'd10, 32'hFFFF_FFEC, 32'hFFFF_FFCE, 32'hFFFF_FFBA};

    localparam int M_ZERO = 0;
    localparam int M_XOR  = 1;
    localparam int M_REAL = 2;
    localparam int M_RAND = 3;

`ifdef ALU_BIST_GOLDEN_CHECK_EN
    localparam bit GOLD = 1'b1;
`else
    localparam bit GOLD = 1'b0;
`endif

    function automatic logic [31:0] alu_fn(input int mode, input logic [31:0] key,
                                           input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (mode)
            M_ZERO: r = 32'h0;
            M_XOR:  r = a ^ b;
            M_REAL: begin
                case (c)
                    4'd0:  r = a + b;
                    4'd1:  r = a - b;
                    4'd2:  r = a & b;
                    4'd3:  r = a | b;
                    4'd4:  r = a ^ b;
                    4'd5:  r = ~(a | b);
                    4'd6:  r = a << b[4:0];
                    4'd7:  r = a >> b[4:0];
                    4'd8:  r = 32'($signed(a) >>> b[4:0]);
                    4'd9:  r = {31'b0, $signed(a) < $signed(b)};
                    4'd10: r = {31'b0, a < b};
                    4'd11: r = a;
                    4'd12: r = b;
                    4'd13: r = ~a;
                    4'd14: r = a + 32'd1;
                    default: r = a * b;
                endcase
            end
            default: r = ((a ^ key) + {b[15:0], b[31:16]}) ^ (key * {28'b0, c});
        endcase
        return r;
    endfunction

    // Signature over the whole sweep: ctrl outer, vector inner, one MISR step per sample.
    function automatic logic [31:0] model_sig(input int mode, input logic [31:0] key, input int flip_idx);
        logic [31:0] s;
        logic [31:0] d;
        s = SEED;
        for (int k = 0; k < NS; k++) begin
            d = alu_fn(mode, key, 4'(k / NV), TA[k % NV], TB[k % NV]);
            if (k == flip_idx) d[0] = ~d[0];
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ d;
        end
        return s;
    endfunction

    localparam logic [31:0] GOLDEN_XOR = model_sig(M_XOR, 32'h0, -1);

    // clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        start_w [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [31:0] a_w     [2];
    logic [31:0] b_w     [2];
    logic [3:0]  ctrl_w  [2];
    logic [31:0] o_w     [2];
    logic [31:0] sig_w   [2];
    logic [7:0]  cnt_w   [2];
    logic        pass_w  [2];
    bit          flip_w  [2];

    int          mode;
    logic [31:0] key;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            o_w[i] = alu_fn(mode, key, ctrl_w[i], a_w[i], b_w[i])
                     ^ {31'b0, flip_w[i] && (cnt_w[i] == 8'd76)};
        end
    end

    alu_bist #(.SETTLE(1), .GOLDEN_SIG(GOLDEN_XOR)) dut (
        .clk(clk), .rst(rst), .start(start_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .alu_a(a_w[1]), .alu_b(b_w[1]), .alu_ctrl(ctrl_w[1]), .alu_o(o_w[1]),
        .signature(sig_w[1]), .vec_cnt(cnt_w[1]), .pass(pass_w[1])
    );

    alu_bist #(.SETTLE(0), .GOLDEN_SIG(GOLDEN_XOR)) dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .alu_a(a_w[0]), .alu_b(b_w[0]), .alu_ctrl(ctrl_w[0]), .alu_o(o_w[0]),
        .signature(sig_w[0]), .vec_cnt(cnt_w[0]), .pass(pass_w[0])
    );

    // scoreboard
    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample monitor on the SETTLE=1 instance: a vec_cnt step means the previous
    // cycle's operands were compacted.
    logic [67:0] prev1;
    logic [7:0]  prev_cnt1;
    logic [67:0] cap_q [$];
    logic [67:0] exp_q [$];
    bit          cap_en;

    always @(negedge clk) begin
        if (cap_en && (cnt_w[1] == prev_cnt1 + 8'd1)) cap_q.push_back(prev1);
        prev1     <= {ctrl_w[1], a_w[1], b_w[1]};
        prev_cnt1 <= cnt_w[1];
    end

    typedef struct {
        int          idx;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } samp_rec_t;

    task automatic run(input int sel, input int exp_e, input int p0, input int p1,
                       input string tag, output logic [31:0] sig_done, output logic pass_done);
        int ndone;
        int first_e;
        ndone    = 0;
        first_e  = -1;
        sig_done = 32'h0;
        pass_done = 1'b0;
        @(negedge clk);
        start_w[sel] = 1'b1;
        @(negedge clk);
        start_w[sel] = 1'b0;
        check({tag, " busy after start"}, 68'(busy_w[sel]), 68'd1);
        check({tag, " pass cleared on start"}, 68'(pass_w[sel]), 68'd0);
        for (int e = 1; e <= exp_e + 20; e++) begin
            @(negedge clk);
            start_w[sel] = (e == p0 || e == p1) ? 1'b1 : 1'b0;
            if (done_w[sel]) begin
                ndone++;
                if (first_e < 0) begin
                    first_e   = e;
                    sig_done  = sig_w[sel];
                    pass_done = pass_w[sel];
                    check({tag, " vec_cnt at done"}, 68'(cnt_w[sel]), 68'd144);
                    check({tag, " busy low at done"}, 68'(busy_w[sel]), 68'd0);
                end
            end
        end
        start_w[sel] = 1'b0;
        check({tag, " done latency"}, 68'(first_e), 68'(exp_e));
        check({tag, " single done"}, 68'(ndone), 68'd1);
    endtask

    logic [31:0] s;
    logic        p;
    samp_rec_t   recs [8];

    initial begin
        recs[0] = '{0,   4'd0,  32'h0,         32'h0};
        recs[1] = '{9,   4'd1,  32'h0,         32'h0};
        recs[2] = '{143, 4'd15, 32'hFFFF_FFC4, 32'hFFFF_FFBA};
        recs[3] = '{1,   4'd0,  32'd1234567890, 32'd876543021};
        recs[4] = '{20,  4'd2,  32'd2345678901, 32'd3456789012};
        recs[5] = '{40,  4'd4,  32'd50,        32'd40};
        recs[6] = '{77,  4'd8,  32'hFFFF_FFF6, 32'd10};
        recs[7] = '{60,  4'd6,  32'd20,        32'hFFFF_FFEC};

        rst = 1'b1;
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        flip_w[0] = 1'b0;
        flip_w[1] = 1'b0;
        mode = M_REAL;
        key = 32'h0;
        cap_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy/done/pass", {busy_w[1], done_w[1], pass_w[1]}, 68'd0);
        check("reset operands", {ctrl_w[1], a_w[1], b_w[1]}, 68'd0);
        check("reset signature", 68'(sig_w[1]), 68'd0);
        check("reset vec_cnt", 68'(cnt_w[1]), 68'd0);
        rst = 1'b0;

        // Real ALU, SETTLE=1: latency, sample order, signature.
        mode = M_REAL;
        cap_en = 1'b1;
        run(1, 288, -1, -1, "real", s, p);
        cap_en = 1'b0;
        check("real signature", 68'(s), 68'(model_sig(M_REAL, 32'h0, -1)));
        for (int c = 0; c < 16; c++)
            for (int v = 0; v < NV; v++)
                exp_q.push_back({4'(c), TA[v], TB[v]});
        check("captured sample count", 68'(cap_q.size()), 68'(NS));
        begin
            int bad;
            bad = -1;
            for (int k = 0; k < NS && k < cap_q.size(); k++)
                if (bad < 0 && cap_q[k] !== exp_q[k]) bad = k;
            check("sample sequence first bad index", 68'(bad + 1), 68'd0);
        end
        for (int i = 0; i < 8; i++) begin
            if (recs[i].idx < cap_q.size())
                check($sformatf("sample %0d operands", recs[i].idx),
                      cap_q[recs[i].idx], {recs[i].c, recs[i].a, recs[i].b});
            else
                check($sformatf("sample %0d present", recs[i].idx), 68'(cap_q.size()), 68'(NS));
        end

        // Hold after run.
        repeat (5) @(negedge clk);
        check("hold signature", 68'(sig_w[1]), 68'(model_sig(M_REAL, 32'h0, -1)));
        check("hold vec_cnt", 68'(cnt_w[1]), 68'd144);
        check("hold operands", {ctrl_w[1], a_w[1], b_w[1]}, {4'd15, 32'hFFFF_FFC4, 32'hFFFF_FFBA});
        check("hold idle", {busy_w[1], done_w[1]}, 68'd0);

        // Stub ALUs.
        mode = M_ZERO;
        run(1, 288, -1, -1, "zero", s, p);
        check("zero signature", 68'(s), 68'(model_sig(M_ZERO, 32'h0, -1)));
        mode = M_XOR;
        run(1, 288, -1, -1, "xor", s, p);
        check("xor signature", 68'(s), 68'(GOLDEN_XOR));
        check("xor pass", 68'(p), 68'(GOLD));

        // Randomised ALU functions on both instances.
        for (int r = 0; r < 3; r++) begin
            mode = M_RAND;
            key = $urandom;
            run(r % 2, (r % 2) ? 288 : 144, -1, -1, $sformatf("rand%0d", r), s, p);
            check($sformatf("rand%0d signature", r), 68'(s), 68'(model_sig(M_RAND, key, -1)));
        end

        // SETTLE=0 with start pulses mid-run.
        mode = M_XOR;
        run(0, 144, 5, 50, "settle0", s, p);
        check("settle0 signature", 68'(s), 68'(GOLDEN_XOR));
        check("settle0 pass", 68'(p), 68'(GOLD));

        // start held high: back-to-back runs through one IDLE cycle.
        begin
            int d1, d2, extra;
            d1 = -1; d2 = -1; extra = 0;
            @(negedge clk);
            start_w[0] = 1'b1;
            for (int e = 0; e <= 300; e++) begin
                @(negedge clk);
                if (e == 200) start_w[0] = 1'b0;
                if (done_w[0]) begin
                    if (d1 < 0) d1 = e;
                    else if (d2 < 0) d2 = e;
                    else extra++;
                end
            end
            start_w[0] = 1'b0;
            check("held start first done", 68'(d1), 68'd144);
            check("held start second done", 68'(d2), 68'd290);
            check("held start extra dones", 68'(extra), 68'd0);
        end

        // Reset mid-run.
        begin
            int nd;
            nd = 0;
            @(negedge clk);
            start_w[1] = 1'b1;
            @(negedge clk);
            start_w[1] = 1'b0;
            for (int e = 1; e < 100; e++) begin
                @(negedge clk);
                if (done_w[1]) nd++;
            end
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("midrst busy/done/pass", {busy_w[1], done_w[1], pass_w[1]}, 68'd0);
            check("midrst operands", {ctrl_w[1], a_w[1], b_w[1]}, 68'd0);
            check("midrst sig/cnt", {sig_w[1], cnt_w[1]}, 68'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int e = 0; e < 320; e++) begin
                @(negedge clk);
                if (done_w[1]) nd++;
            end
            check("midrst no done", 68'(nd), 68'd0);
            run(1, 288, -1, -1, "after rst", s, p);
            check("after rst signature", 68'(s), 68'(GOLDEN_XOR));
        end

        // Corrupted sample 77 must change the signature and fail the golden check.
        flip_w[1] = 1'b1;
        run(1, 288, -1, -1, "fault", s, p);
        flip_w[1] = 1'b0;
        check("fault signature", 68'(s), 68'(model_sig(M_XOR, 32'h0, 76)));
        check("fault pass", 68'(p), 68'd0);
        run(1, 288, -1, -1, "clean", s, p);
        check("clean pass", 68'(p), 68'(GOLD));

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Hardware self-test sequencer for the 32-bit combinational ALU.
- Acts as the driving and checking end of the ALU interface. It applies a fixed operand-vector set for every ctrl code 0..15.
- Each ALU result is compacted into a 32-bit MISR signature.
- Used at bring-up and in silicon self-test; sits beside the ALU in the datapath test wrapper.

Parameters:
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU ctrl width; all 2**CTRL_W codes are swept
- SETTLE, 1, idle cycles after a vector is applied before sampling (0 allowed)
- MISR_POLY, 32'h04C11DB7, MISR feedback polynomial
- MISR_SEED, 32'hFFFFFFFF, signature value loaded on start
- GOLDEN_SIG, 32'h00000000, expected final signature (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- alu_a  out  WIDTH  ALU operand a
- alu_b  out  WIDTH  ALU operand b
- alu_ctrl  out  CTRL_W  ALU operation select
- alu_o  in  WIDTH  ALU result
- signature  out  WIDTH  MISR value; final after done
- vec_cnt  out  8  count of results compacted this run
- pass  out  1  signature matched GOLDEN_SIG

Behaviour:
- Clocking and reset (fixed): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE. signature resets to 0, not to the seed.
- Vector table, 9 entries, 32-bit two's complement, (a,b):
  - (0,0)
  - (1234567890,876543021)
  - (2345678901,3456789012)
  - (30,40)
  - (50,40)
  - (-10,10)
  - (20,-20)
  - (-60,-50)
  - (-60,-70)
- Sweep order: outer loop ctrl 0..15, inner loop vector 0..8. Total 144 samples.
- States: IDLE -> WAIT -> SAMPLE -> (WAIT | FINISH) -> IDLE.
- IDLE, start=1 at an edge:
  - load ctrl 0 and vector 0 onto the outputs;
  - signature <= MISR_SEED, vec_cnt <= 0, pass <= 0, busy <= 1;
  - next state WAIT, or SAMPLE directly if SETTLE=0.
- WAIT: counts SETTLE cycles with outputs held, then goes to SAMPLE.
- SAMPLE (one cycle):
  - at the edge, signature <= {sig[30:0],0} ^ (sig[31] ? MISR_POLY : 0) ^ alu_o;
  - vec_cnt increments;
  - the next vector/ctrl loads at the same edge.
  - After sample 144, go to FINISH.
- FINISH (one cycle): done=1, busy=0. Next cycle returns to IDLE.
- Hold after run: signature, vec_cnt and pass hold until the next accepted start. alu_a/alu_b/alu_ctrl hold their last values.
- Latency: done is high during the cycle that begins 144*(SETTLE+1) edges after the start edge. With SETTLE=1 that is 288 edges.
- start while busy or in FINISH: ignored, no restart.
- start held high continuously: a new run begins in the cycle after FINISH.
- rst mid-run: immediate return to reset values; no done pulse.
- The ctrl counter wraps only through FINISH; no code beyond 15 is ever driven.

Optional Feature:
- Macro: ALU_BIST_GOLDEN_CHECK_EN.
- Defined: at the edge entering FINISH, pass <= (final signature == GOLDEN_SIG). pass is valid from the done cycle and is cleared on the next start.
- Not defined: pass is tied to 0 and GOLDEN_SIG is unused. All other behaviour is identical.

Decomposition:
- Package alu_bist_pkg:
  - state enum (IDLE, WAIT, SAMPLE, FINISH);
  - NUM_VEC=9 and the vector ROM as constant arrays of a and b;
  - default MISR_POLY and MISR_SEED.
- Sub-module alu_bist_misr:
  - ports: clk, rst, load_seed, shift_en, data_in, sig_out;
  - parameterised by WIDTH, MISR_POLY and MISR_SEED.

Test Plan:
1. rst pulse, then start=1 for 1 cycle, SETTLE=1, real ALU -> busy=1 next cycle; done pulses exactly 288 edges after the start edge, for one cycle; vec_cnt=144.
2. Monitor each SAMPLE cycle:
   - first sample: ctrl=0, a=0, b=0;
   - 10th sample: ctrl=1, a=0, b=0;
   - last sample: ctrl=15, a=32'hFFFFFFC4, b=32'hFFFFFFBA.
3. Stub ALU returning o=0, then o=a^b -> signature equals the bench MISR model seeded 32'hFFFFFFFF over 144 samples.
4. SETTLE=0 -> done after exactly 144 edges. Pulsing start at cycles 5 and 50 of the run -> ignored; exactly one done.
5. rst asserted at cycle 100 of a run -> all outputs 0 asynchronously, no done. A new start then completes a full 288-edge run with the same signature as test 3.
6. With ALU_BIST_GOLDEN_CHECK_EN defined:
   - GOLDEN_SIG = model signature -> pass=1;
   - flip alu_o bit 0 on sample 77 -> pass=0.
   - Macro undefined -> pass stays 0.
